line_mem_arbiter: RTL and testbench

LINE_MEM_ARBITER -- requirements
Module: line_mem_arbiter

---
 rtl/line_mem_arbiter_if.sv | 35 +++
 rtl/line_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_line_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory line-transfer signals around the arbiter.
// slave is the arbiter's view; master is the caches/memory view.
interface line_mem_arbiter_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 256
);
    logic                       i_strobe;
    logic [ADDR_WIDTH-1:0]      i_addr;
    logic                       i_done;
    logic [CACHE_LINE_SIZE-1:0] i_datain;

    logic                       d_strobe;
    logic [ADDR_WIDTH-1:0]      d_addr;
    logic                       d_rw;
    logic [CACHE_LINE_SIZE-1:0] d_dataout;
    logic                       d_done;
    logic [CACHE_LINE_SIZE-1:0] d_datain;

    logic                       m_strobe;
    logic [ADDR_WIDTH-1:0]      m_addr;
    logic                       m_rw;
    logic [CACHE_LINE_SIZE-1:0] m_dout;
    logic                       m_done;
    logic [CACHE_LINE_SIZE-1:0] m_din;

    modport slave (
        input  i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_din,
        output i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dout
    );

    modport master (
        output i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_din,
        input  i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dout
    );
endinterface

// File: rtl/line_mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache with round-robin
// arbitration and a single outstanding transaction.
module line_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 256
) (
    input  logic                clk,
    input  logic                rst,
    line_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_e                     state_q, state_d;
    logic                       i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic [ADDR_WIDTH-1:0]      i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic                       d_rw_q, d_rw_d;
    logic [CACHE_LINE_SIZE-1:0] d_wdata_q, d_wdata_d;
    logic                       grant_q, grant_d, last_grant_q, last_grant_d;
    logic                       m_strobe_q, m_strobe_d, m_rw_q, m_rw_d;
    logic [ADDR_WIDTH-1:0]      m_addr_q, m_addr_d;
    logic [CACHE_LINE_SIZE-1:0] m_dout_q, m_dout_d;
    logic                       i_done_q, i_done_d, d_done_q, d_done_d;
    logic [CACHE_LINE_SIZE-1:0] i_datain_q, i_datain_d, d_datain_q, d_datain_d;
    logic                       i_clear, d_clear, i_accept, d_accept;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_strobe_d   = 1'b0;
        m_addr_d     = m_addr_q;
        m_rw_d       = m_rw_q;
        m_dout_d     = m_dout_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        i_datain_d   = i_datain_q;
        d_datain_d   = d_datain_q;

        unique case (state_q)
            IDLE: begin
                if (i_pend_q || d_pend_q) begin
                    // D wins when it is alone or when I was served last.
                    grant_d    = (d_pend_q && (!i_pend_q || last_grant_q == PORT_I)) ? PORT_D : PORT_I;
                    m_strobe_d = 1'b1;
                    state_d    = ISSUE;
                    if (grant_d == PORT_D) begin
                        m_addr_d = d_addr_q;
                        m_rw_d   = d_rw_q;
                        m_dout_d = d_wdata_q;
                    end else begin
                        m_addr_d = i_addr_q;
                        m_rw_d   = 1'b0;
                        m_dout_d = '0;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.m_done) begin
                    if (grant_q == PORT_I) begin
                        i_datain_d = bus.m_din;
                        i_done_d   = 1'b1;
                    end else begin
                        // m_rw_q still holds the granted direction; d_rw_q may be reloaded in RESP.
                        if (!m_rw_q) d_datain_d = bus.m_din;
                        d_done_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A port frees up in its done cycle, so a strobe in that same cycle is taken.
    always_comb begin
        i_clear   = (state_q == RESP) && (grant_q == PORT_I);
        d_clear   = (state_q == RESP) && (grant_q == PORT_D);
        i_accept  = bus.i_strobe && (!i_pend_q || i_clear);
        d_accept  = bus.d_strobe && (!d_pend_q || d_clear);
        i_pend_d  = i_accept ? 1'b1 : (i_clear ? 1'b0 : i_pend_q);
        d_pend_d  = d_accept ? 1'b1 : (d_clear ? 1'b0 : d_pend_q);
        i_addr_d  = i_accept ? bus.i_addr    : i_addr_q;
        d_addr_d  = d_accept ? bus.d_addr    : d_addr_q;
        d_rw_d    = d_accept ? bus.d_rw      : d_rw_q;
        d_wdata_d = d_accept ? bus.d_dataout : d_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            i_pend_q     <= 1'b0;
            d_pend_q     <= 1'b0;
            i_addr_q     <= '0;
            d_addr_q     <= '0;
            d_rw_q       <= 1'b0;
            d_wdata_q    <= '0;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_I;
            m_strobe_q   <= 1'b0;
            m_addr_q     <= '0;
            m_rw_q       <= 1'b0;
            m_dout_q     <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_datain_q   <= '0;
            d_datain_q   <= '0;
        end else begin
            state_q      <= state_d;
            i_pend_q     <= i_pend_d;
            d_pend_q     <= d_pend_d;
            i_addr_q     <= i_addr_d;
            d_addr_q     <= d_addr_d;
            d_rw_q       <= d_rw_d;
            d_wdata_q    <= d_wdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_strobe_q   <= m_strobe_d;
            m_addr_q     <= m_addr_d;
            m_rw_q       <= m_rw_d;
            m_dout_q     <= m_dout_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_datain_q   <= i_datain_d;
            d_datain_q   <= d_datain_d;
        end
    end

    assign bus.m_strobe = m_strobe_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_rw     = m_rw_q;
    assign bus.m_dout   = m_dout_q;
    assign bus.i_done   = i_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.i_datain = i_datain_q;
    assign bus.d_datain = d_datain_q;
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench for line_mem_arbiter: a negedge monitor holds the request/response
// model and the memory responder; the stimulus process only drives pins.
module tb_line_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_mem_arbiter_if #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) bif ();
    line_mem_arbiter #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave)
    );

    logic m_done_mem   = 1'b0;
    logic m_done_stray = 1'b0;
    assign bif.m_done = m_done_mem | m_done_stray;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [LW-1:0] data;
        int            acc;
        bit            issued;
    } req_t;

    typedef struct {
        int            port;
        logic          rw;
        logic [LW-1:0] data;
        int            cyc;
    } rsp_t;

    // model state, written only by the monitor
    req_t          req [2];
    bit            pend [2];
    logic [LW-1:0] hold [2];
    rsp_t          exp_q [$];
    int            last_port = 0;
    int            cyc = 0;
    int            mem_cnt = 0, mem_port = 0;
    bit            mem_live = 0;
    logic          mem_rw = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    bit            rst_prev = 1'b1;
    bit            to_seen = 1'b0;
    int            checks = 0, errors = 0;

    // knobs, written only by the stimulus
    int mem_lat = 1;
    bit chk_lat = 1'b0;
    bit to_flag = 1'b0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // monitor + memory responder
    initial begin : monitor
        logic          dn;
        logic [LW-1:0] din;
        logic [LW-1:0] line;
        rsp_t          r;
        int            p, o;
        bif.m_din = '0;
        for (int q = 0; q < 2; q++) begin
            pend[q] = 0;
            hold[q] = '0;
            req[q]  = '{addr: '0, rw: 1'b0, data: '0, acc: 0, issued: 1'b0};
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (to_flag && !to_seen) begin
                to_seen = 1'b1;
                chk("timeout", 1, 0);
            end
            if (!rst_prev)
                chk("reset_outputs", {bif.m_strobe, bif.i_done, bif.d_done, bif.m_rw, |bif.m_addr,
                                      |bif.m_dout, |bif.i_datain, |bif.d_datain}, 0);

            // responses
            for (int q = 0; q < 2; q++) begin
                dn  = (q == 0) ? bif.i_done : bif.d_done;
                din = (q == 0) ? bif.i_datain : bif.d_datain;
                if (dn) begin
                    if (exp_q.size() == 0 || exp_q[0].port != q) begin
                        chk(q == 0 ? "spurious_i_done" : "spurious_d_done", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        if (!r.rw) hold[q] = r.data;
                        chk("done_cycle", cyc, r.cyc + 1);
                        chk(q == 0 ? "i_datain" : "d_datain", din, hold[q]);
                        if (chk_lat) chk("done_latency", cyc, req[q].acc + 4);
                        pend[q]   = 0;
                        last_port = q;
                    end
                end else begin
                    chk(q == 0 ? "i_datain_hold" : "d_datain_hold", din, hold[q]);
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
                r = exp_q.pop_front();
                chk("missing_done", 0, 1);
                pend[r.port] = 0;
            end

            // memory side
            m_done_mem = 1'b0;
            if (bif.m_strobe) begin
                p = -1;
                for (int q = 0; q < 2; q++)
                    if (pend[q] && !req[q].issued && bif.m_addr == req[q].addr && bif.m_rw == req[q].rw &&
                        (!req[q].rw || bif.m_dout == req[q].data))
                        p = q;
                chk("mstrobe_matches_pending", p >= 0, 1);
                chk("one_outstanding", mem_cnt > 0 && mem_live, 0);
                if (p >= 0) begin
                    o = 1 - p;
                    chk("round_robin", p == last_port && pend[o] && req[o].acc <= cyc - 2, 0);
                    if (chk_lat) chk("issue_latency", cyc, req[p].acc + 2);
                    req[p].issued = 1'b1;
                    mem_port = p;
                    mem_rw   = req[p].rw;
                    mem_addr = req[p].addr;
                    mem_live = 1'b1;
                    mem_cnt  = mem_lat;
                end
            end else if (mem_cnt > 0) begin
                if (mem_live) chk("m_addr_stable", bif.m_addr, mem_addr);
                mem_cnt--;
                if (mem_cnt == 0) begin
                    line       = rand_line();
                    bif.m_din  = line;
                    m_done_mem = 1'b1;
                    if (mem_live) exp_q.push_back('{port: mem_port, rw: mem_rw, data: line, cyc: cyc});
                    mem_live = 1'b0;
                end
            end

            // requests: a port is free again right after its done was consumed above
            if (rst) begin
                if (bif.i_strobe && !pend[0]) begin
                    pend[0] = 1;
                    req[0]  = '{addr: bif.i_addr, rw: 1'b0, data: '0, acc: cyc, issued: 1'b0};
                end
                if (bif.d_strobe && !pend[1]) begin
                    pend[1] = 1;
                    req[1]  = '{addr: bif.d_addr, rw: bif.d_rw, data: bif.d_dataout, acc: cyc, issued: 1'b0};
                end
            end else begin
                pend[0] = 0;
                pend[1] = 0;
                hold[0] = '0;
                hold[1] = '0;
                last_port = 0;
                exp_q.delete();
                mem_live = 1'b0;
            end
            rst_prev = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((pend[0] || pend[1] || exp_q.size() > 0 || mem_cnt > 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) to_flag = 1'b1;
        repeat (2) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) step();
        rst = 1'b1;
        step();
    endtask

    initial begin : stimulus
        logic [LW-1:0] pat_b;
        bif.i_strobe = 1'b0; bif.i_addr = '0;
        bif.d_strobe = 1'b0; bif.d_addr = '0; bif.d_rw = 1'b0; bif.d_dataout = '0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // single I read at minimum latency
        chk_lat = 1'b1; mem_lat = 1;
        bif.i_strobe = 1'b1; bif.i_addr = 32'h8000_0100;
        step();
        bif.i_strobe = 1'b0;
        wait_idle(50);

        // single D write: d_datain must not move
        pat_b = rand_line();
        bif.d_strobe = 1'b1; bif.d_rw = 1'b1; bif.d_addr = 32'h8000_0200; bif.d_dataout = pat_b;
        step();
        bif.d_strobe = 1'b0;
        wait_idle(50);
        chk_lat = 1'b0;

        // simultaneous pairs after reset, twice
        do_reset(2);
        for (int n = 0; n < 2; n++) begin
            bif.i_strobe = 1'b1; bif.i_addr = 32'h1000_0000 + n * 32'h40;
            bif.d_strobe = 1'b1; bif.d_addr = 32'h2000_0001 + n * 32'h40; bif.d_rw = 1'b0;
            step();
            bif.i_strobe = 1'b0; bif.d_strobe = 1'b0;
            wait_idle(60);
        end

        // second D strobe while pending is dropped
        mem_lat = 3;
        bif.d_strobe = 1'b1; bif.d_rw = 1'b0; bif.d_addr = 32'h3000_0001;
        step();
        bif.d_addr = 32'h3000_0081;
        step();
        bif.d_strobe = 1'b0;
        wait_idle(60);

        // stray m_done while idle
        m_done_stray = 1'b1;
        step();
        m_done_stray = 1'b0;
        repeat (4) step();

        // reset while waiting on memory; late m_done follows two cycles later
        bif.i_strobe = 1'b1; bif.i_addr = 32'h4000_0000;
        step();
        bif.i_strobe = 1'b0;
        for (int k = 0; k < 20 && !bif.m_strobe; k++) step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (6) step();

        // arbiter back in IDLE: full-speed request again
        chk_lat = 1'b1; mem_lat = 1;
        bif.i_strobe = 1'b1; bif.i_addr = 32'h8000_0100;
        step();
        bif.i_strobe = 1'b0;
        wait_idle(50);
        chk_lat = 1'b0;

        // random traffic
        for (int k = 0; k < 600; k++) begin
            bif.i_strobe  = ($urandom_range(0, 2) == 0);
            bif.i_addr    = $urandom & ~32'h1;
            bif.d_strobe  = ($urandom_range(0, 2) == 0);
            bif.d_addr    = $urandom | 32'h1;
            bif.d_rw      = $urandom_range(0, 1) == 1;
            bif.d_dataout = rand_line();
            mem_lat       = $urandom_range(1, 4);
            step();
        end
        bif.i_strobe = 1'b0; bif.d_strobe = 1'b0;
        wait_idle(200);
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
